// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode/state enums and flag bit positions for alu_seq
package alu_pkg;
  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_MUL = 3'b111
  } alu_op_e;
  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} alu_state_e;
  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;
  function automatic logic [3:0] pack_flags(input logic n, input logic z, input logic c, input logic v);
    pack_flags = '0;
    pack_flags[FLG_N] = n;
    pack_flags[FLG_Z] = z;
    pack_flags[FLG_C] = c;
    pack_flags[FLG_V] = v;
  endfunction
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response valid-ready bundle between operand fetch and write-back
interface alu_seq_if #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       ALUControl;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] ALUResult;
  logic [3:0]       flags;
  logic             out_valid;
  logic             out_ready;
  modport master (output A, B, ALUControl, in_valid, out_ready, input in_ready, ALUResult, flags, out_valid);
  modport slave  (input A, B, ALUControl, in_valid, out_ready, output in_ready, ALUResult, flags, out_valid);
endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add multiplier, one multiplier bit per cycle, done on the WIDTH-th cycle
module alu_mul_seq #(parameter int WIDTH = 16) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] prod_o
);
  localparam int CW = $clog2(WIDTH + 1);
  logic               busy_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  assign acc_d  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done_o = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign prod_o = acc_d;
  // load operands on start, then accumulate one partial product per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      mplier_q <= b_i;
      acc_q    <= '0;
    end else if (busy_q) begin
      busy_q   <= !done_o;
      cnt_q    <= cnt_q + 1'b1;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      acc_q    <= acc_d;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result/flags and an iterative MUL
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);
  localparam int M = WIDTH - 1;
  alu_state_e         state_q, state_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [3:0]         flg_q, flg_d;
  logic               ov_q, ov_d;
  alu_op_e            op;
  logic               hs, mul_start, mul_done;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     sum, diff;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v;
  assign op            = alu_op_e'(bus.ALUControl);
  assign bus.in_ready  = (state_q == IDLE) && (!ov_q || bus.out_ready);
  assign hs            = bus.in_valid && bus.in_ready;
  assign mul_start     = hs && (op == OP_MUL);
  assign sum           = {1'b0, bus.A} + {1'b0, bus.B};
  assign diff          = {1'b0, bus.A} - {1'b0, bus.B};
  assign bus.ALUResult = res_q;
  assign bus.flags     = flg_q;
  assign bus.out_valid = ov_q;
  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (mul_start),
    .a_i     (bus.A),
    .b_i     (bus.B),
    .done_o  (mul_done),
    .prod_o  (prod)
  );
  // single-cycle datapath; diff[WIDTH] is the unsigned borrow
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_AND: alu_res = bus.A & bus.B;
      OP_OR:  alu_res = bus.A | bus.B;
      OP_XOR: alu_res = bus.A ^ bus.B;
      OP_SLL: alu_res = bus.A << bus.B[SHW-1:0];
      OP_SRL: alu_res = bus.A >> bus.B[SHW-1:0];
      OP_ADD: begin
        alu_res = sum[M:0];
        alu_c   = sum[WIDTH];
        alu_v   = (bus.A[M] == bus.B[M]) && (sum[M] != bus.A[M]);
      end
      OP_SUB: begin
        alu_res = diff[M:0];
        alu_c   = diff[WIDTH];
        alu_v   = (bus.A[M] != bus.B[M]) && (diff[M] != bus.A[M]);
      end
      default: alu_res = '0;
    endcase
  end
  // next state and output-register update; a fresh result wins over consumption
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    flg_d   = flg_q;
    ov_d    = ov_q && !bus.out_ready;
    if (mul_start) state_d = MUL;
    else if (state_q == MUL && mul_done) state_d = IDLE;
    if (hs && op != OP_MUL) begin
      res_d = alu_res;
      flg_d = pack_flags(alu_res[M], alu_res == '0, alu_c, alu_v);
      ov_d  = 1'b1;
    end else if (mul_done) begin
      res_d = prod[M:0];
      flg_d = pack_flags(prod[M], prod[M:0] == '0, |prod[2*WIDTH-1:WIDTH], 1'b0);
      ov_d  = 1'b1;
    end
  end
  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      res_q   <= '0;
      flg_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
      ov_q    <= ov_d;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against an arithmetic reference model
module tb_alu_seq;
  localparam int W = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [19:0] model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int ua, ub, sa, sb, r;
    longint p;
    logic [15:0] res;
    logic c, v;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    c = 1'b0;
    v = 1'b0;
    res = '0;
    case (op)
      3'd0: res = a & b;
      3'd1: res = a | b;
      3'd2: begin r = ua + ub; res = r[15:0]; c = r > 65535; v = (sa + sb > 32767) || (sa + sb < -32768); end
      3'd3: begin r = ua - ub; res = r[15:0]; c = ua < ub; v = (sa - sb > 32767) || (sa - sb < -32768); end
      3'd4: res = a ^ b;
      3'd5: res = a << (ub % 16);
      3'd6: res = a >> (ub % 16);
      default: begin p = longint'(ua) * longint'(ub); res = p[15:0]; c = p > 65535; end
    endcase
    return {res, res[15], res == 16'h0, c, v};
  endfunction
  task automatic do_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [19:0] e;
    int w;
    e = model(op, a, b);
    bus.A = a;
    bus.B = b;
    bus.ALUControl = op;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    w = 0;
    while (!bus.in_ready && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 40) chk("in_ready_timeout", 32'(w), 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.A = 16'($urandom);
    bus.B = 16'($urandom);
    bus.ALUControl = 3'($urandom);
    if (op == 3'd7) begin
      for (int i = 0; i < W; i++) begin
        chk("mul_busy_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mul_busy_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
      end
    end
    chk("out_valid", 32'(bus.out_valid), 32'd1);
    chk("result", 32'(bus.ALUResult), 32'(e[19:4]));
    chk("flags", 32'(bus.flags), 32'(e[3:0]));
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [19:0] e;
    logic [2:0] op;
    logic [15:0] a, b;
    bus.A = '0;
    bus.B = '0;
    bus.ALUControl = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", 32'(bus.ALUResult), 32'd0);
    chk("rst_flags", 32'(bus.flags), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    do_op(3'd2, 16'h7FFF, 16'h0001);
    chk("add_ovf_res", 32'(bus.ALUResult), 32'h8000);
    chk("add_ovf_flags", 32'(bus.flags), 32'b1001);
    do_op(3'd3, 16'h0003, 16'h0005);
    chk("sub_neg_res", 32'(bus.ALUResult), 32'hFFFE);
    chk("sub_neg_flags", 32'(bus.flags), 32'b1010);
    do_op(3'd3, 16'h1234, 16'h1234);
    chk("sub_zero_res", 32'(bus.ALUResult), 32'h0000);
    chk("sub_zero_flags", 32'(bus.flags), 32'b0100);
    do_op(3'd7, 16'h0100, 16'h0101);
    chk("mul_hi_res", 32'(bus.ALUResult), 32'h0100);
    chk("mul_hi_flags", 32'(bus.flags), 32'b0010);
    do_op(3'd7, 16'h00FF, 16'h00FF);
    chk("mul_lo_res", 32'(bus.ALUResult), 32'hFE01);
    chk("mul_lo_flags", 32'(bus.flags), 32'b1000);
    do_op(3'd5, 16'h0001, 16'h0013);
    chk("sll_res", 32'(bus.ALUResult), 32'h0008);
    do_op(3'd6, 16'h8000, 16'd15);
    chk("srl_res", 32'(bus.ALUResult), 32'h0001);
    do_op(3'd0, 16'hF0F0, 16'h3C3C);
    chk("and_res", 32'(bus.ALUResult), 32'h3030);
    bus.out_ready = 1'b0;
    bus.A = 16'h00FF;
    bus.B = 16'h0F0F;
    bus.ALUControl = 3'd4;
    bus.in_valid = 1'b1;
    #1;
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_in_ready_hold", 32'(bus.in_ready), 32'd0);
      chk("bp_out_valid_hold", 32'(bus.out_valid), 32'd1);
      chk("bp_result_hold", 32'(bus.ALUResult), 32'h3030);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("bp_new_out_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_new_result", 32'(bus.ALUResult), 32'h0FF0);
    @(posedge clk); #1;
    chk("consumed_out_valid", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 6));
      a = 16'($urandom);
      b = 16'($urandom);
      e = model(op, a, b);
      bus.A = a;
      bus.B = b;
      bus.ALUControl = op;
      @(posedge clk); #1;
      chk("stream_out_valid", 32'(bus.out_valid), 32'd1);
      chk("stream_result", 32'(bus.ALUResult), 32'(e[19:4]));
      chk("stream_flags", 32'(bus.flags), 32'(e[3:0]));
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 16'h8000 >> $urandom_range(0, 15) : 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      do_op(3'($urandom), a, b);
    end
    do_op(3'd3, 16'h0003, 16'h0005);
    bus.A = 16'h1234;
    bus.B = 16'h5678;
    bus.ALUControl = 3'd7;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("rmul_in_ready", 32'(bus.in_ready), 32'd0);
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rmul_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rmul_result", 32'(bus.ALUResult), 32'd0);
    chk("rmul_flags", 32'(bus.flags), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rmul_in_ready_after", 32'(bus.in_ready), 32'd1);
    repeat (12) @(posedge clk);
    #1;
    chk("rmul_no_stray_valid", 32'(bus.out_valid), 32'd0);
    do_op(3'd2, 16'd2, 16'd3);
    chk("post_reset_add", 32'(bus.ALUResult), 32'h0005);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
